// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle DIV/DIVU unit.
package div_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;

    // Handshake encodings shared with the EX stage
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_ANNUL            = 1'b1;

    // ALU op encodings decoded in ID and carried through EX
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    // {HI, LO} = {remainder, quotient}
    typedef struct packed {
        logic [DATA_W-1:0] rem;
        logic [DATA_W-1:0] quo;
    } div_result_t;

    // Two's complement negate when requested
    function automatic logic [DATA_W-1:0] neg_if(input logic neg, input logic [DATA_W-1:0] x);
        return neg ? DATA_W'(-x) : x;
    endfunction

    // Magnitude of an operand in signed mode, raw value otherwise
    function automatic logic [DATA_W-1:0] abs_if(input logic sgn, input logic [DATA_W-1:0] x);
        return neg_if(sgn & x[DATA_W-1], x);
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX <-> divider request/response bundle.
interface div_unit_if;
    import div_unit_pkg::*;

    logic              signed_div_i;
    logic [DATA_W-1:0] opdata1_i;
    logic [DATA_W-1:0] opdata2_i;
    logic              start_i;
    logic              annul_i;
    div_result_t       result_o;
    logic              ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit_step.sv
// One restoring shift/compare/subtract iteration producing one quotient bit.
module div_unit_step
    import div_unit_pkg::*;
(
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_quo,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_quo
);
    logic [DATA_W:0] w_sh;
    logic            w_ge;

    // Partial remainder stays below the divisor, so the shifted value needs one extra bit
    assign w_sh  = {i_rem, i_quo[DATA_W-1]};
    assign w_ge  = (w_sh >= {1'b0, i_divisor});
    // When w_ge holds the true difference fits in DATA_W bits, so modular subtract is exact
    assign o_rem = w_ge ? (w_sh[DATA_W-1:0] - i_divisor) : w_sh[DATA_W-1:0];
    assign o_quo = {i_quo[DATA_W-2:0], w_ge};
endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; one quotient bit per cycle.
module div_unit (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    import div_unit_pkg::*;

    div_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_div;
    logic              r_qneg;
    logic              r_rneg;
    logic              r_ready;
    div_result_t       r_result;

    logic [DATA_W-1:0] w_rem;
    logic [DATA_W-1:0] w_quo;
    logic              w_req;
    logic              w_annul;

    assign w_annul = (bus.annul_i == DIV_ANNUL);
    assign w_req   = (bus.start_i == DIV_START) && !w_annul;

    div_unit_step u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_rem),
        .o_quo     (w_quo)
    );

    // Control FSM, operand latch, iteration and sign fix; outputs loaded on entry to END
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= DIV_FREE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_ready  <= DIV_RESULT_NOT_READY;
            r_result <= '0;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    r_ready  <= DIV_RESULT_NOT_READY;
                    r_result <= '0;
                    if (w_req) begin
                        if (bus.opdata2_i == '0) begin
                            r_state <= DIV_BYZERO;
                        end else begin
                            r_state <= DIV_ON;
                            r_cnt   <= '0;
                            r_rem   <= '0;
                            r_quo   <= abs_if(bus.signed_div_i, bus.opdata1_i);
                            r_div   <= abs_if(bus.signed_div_i, bus.opdata2_i);
                            r_qneg  <= bus.signed_div_i &
                                       (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                            r_rneg  <= bus.signed_div_i & bus.opdata1_i[DATA_W-1];
                        end
                    end
                end
                DIV_BYZERO: begin
                    if (w_annul) begin
                        r_state <= DIV_FREE;
                    end else begin
                        r_state  <= DIV_END;
                        r_ready  <= DIV_RESULT_READY;
                        r_result <= '0;
                    end
                end
                DIV_ON: begin
                    if (w_annul) begin
                        r_state <= DIV_FREE;
                    end else begin
                        r_rem <= w_rem;
                        r_quo <= w_quo;
                        r_cnt <= CNT_W'(r_cnt + 1'b1);
                        if (r_cnt == CNT_W'(DATA_W - 1)) begin
                            r_state      <= DIV_END;
                            r_ready      <= DIV_RESULT_READY;
                            r_result.rem <= neg_if(r_rneg, w_rem);
                            r_result.quo <= neg_if(r_qneg, w_quo);
                        end
                    end
                end
                DIV_END: begin
                    if (bus.start_i == DIV_STOP) begin
                        r_state  <= DIV_FREE;
                        r_ready  <= DIV_RESULT_NOT_READY;
                        r_result <= '0;
                    end
                end
                default: r_state <= DIV_FREE;
            endcase
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;
endmodule
